// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO pointer/flag controller.
// Holds the controller state encoding, default geometry and threshold values,
// and a helper that turns an address width into a FIFO depth.
package fifo_pkg;

  localparam int unsigned ADDR_W_DEF = 8;
  localparam int unsigned DEPTH_DEF  = 2 ** ADDR_W_DEF;
  localparam int unsigned AF_LVL_DEF = 252;
  localparam int unsigned AE_LVL_DEF = 4;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_PART  = 2'd1,
    S_FULL  = 2'd2,
    S_FLUSH = 2'd3
  } state_t;

  // Depth of a FIFO addressed by aw bits.
  function automatic int unsigned depth_of(input int unsigned aw);
    return 2 ** aw;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO address pointer.
// Ports:
//   clk_i   clock
//   clr_i   asynchronous active-high clear
//   ce_i    advance the pointer by one (wraps modulo 2**ADDR_W)
//   sclr_i  synchronous clear, takes priority over ce_i
//   ptr_o   current pointer value
module fifo_ptr
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_i,
  input  logic              clr_i,
  input  logic              ce_i,
  input  logic              sclr_i,
  output logic [ADDR_W-1:0] ptr_o
);

  logic [ADDR_W-1:0] ptr_q;
  logic [ADDR_W-1:0] ptr_d;

  // Next pointer: clear beats advance; natural overflow gives the wrap.
  always_comb begin
    ptr_d = ptr_q;
    if (sclr_i) begin
      ptr_d = '0;
    end else if (ce_i) begin
      ptr_d = ptr_q + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge clr_i) begin
    if (clr_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/fifo_ctrl.sv
// Pointer and flag controller for the FIFO_mix buffer.
// Gates producer/consumer requests into RAM strobes, steps the write/read
// pointers and keeps occupancy plus full/empty/almost/sticky-error flags.
// Ports:
//   CLK, CLR            clock, asynchronous active-high reset
//   WR_REQ, RD_REQ      producer / consumer requests
//   FLUSH               synchronous flush pulse (beats every request)
//   ERR_CLR             clears OVF/UDF (a same-cycle set wins)
//   WR_EN, RD_EN        accepted write/read strobes (combinational)
//   WR_ADDR, RD_ADDR    current pointers
//   LEVEL               occupancy 0..2**ADDR_W
//   FULL, EMPTY, AFULL, AEMPTY, OVF, UDF   registered flags
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned AF_LVL = AF_LVL_DEF,
  parameter int unsigned AE_LVL = AE_LVL_DEF
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic              WR_REQ,
  input  logic              RD_REQ,
  input  logic              FLUSH,
  input  logic              ERR_CLR,
  output logic              WR_EN,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] WR_ADDR,
  output logic [ADDR_W-1:0] RD_ADDR,
  output logic [ADDR_W:0]   LEVEL,
  output logic              FULL,
  output logic              EMPTY,
  output logic              AFULL,
  output logic              AEMPTY,
  output logic              OVF,
  output logic              UDF
);

  localparam int unsigned LVL_W = ADDR_W + 1;
  localparam int unsigned DEPTH = depth_of(ADDR_W);

  state_t           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             in_flush_c;
  logic             wr_en_c;
  logic             rd_en_c;

  // Strobes come from registered flags, so no request can fall through.
  assign in_flush_c = (state_q == S_FLUSH);
  assign wr_en_c    = WR_REQ & ~full_q  & ~FLUSH & ~in_flush_c;
  assign rd_en_c    = RD_REQ & ~empty_q & ~FLUSH & ~in_flush_c;

  // Next state, occupancy and flags; full/empty follow LEVEL, never pointers.
  always_comb begin
    state_d = state_q;
    level_d = level_q;

    if (FLUSH) begin
      state_d = S_FLUSH;
      level_d = '0;
    end else begin
      case (state_q)
        S_FLUSH: begin
          state_d = S_EMPTY;
          level_d = '0;
        end
        default: begin
          case ({wr_en_c, rd_en_c})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
          endcase
          if (level_d == '0) begin
            state_d = S_EMPTY;
          end else if (level_d == LVL_W'(DEPTH)) begin
            state_d = S_FULL;
          end else begin
            state_d = S_PART;
          end
        end
      endcase
    end

    full_d   = (state_d == S_FULL);
    empty_d  = (state_d == S_EMPTY) || (state_d == S_FLUSH);
    afull_d  = (level_d >= LVL_W'(AF_LVL));
    aempty_d = (level_d <= LVL_W'(AE_LVL));

    // Requests dropped by a flush never count as errors.
    ovf_d = (WR_REQ & full_q & ~FLUSH) | (ovf_q & ~ERR_CLR);
    udf_d = (RD_REQ & empty_q & ~FLUSH & ~in_flush_c) | (udf_q & ~ERR_CLR);
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q  <= S_EMPTY;
      level_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      level_q  <= level_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wr_ptr (
    .clk_i  (CLK),
    .clr_i  (CLR),
    .ce_i   (wr_en_c),
    .sclr_i (FLUSH),
    .ptr_o  (WR_ADDR)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rd_ptr (
    .clk_i  (CLK),
    .clr_i  (CLR),
    .ce_i   (rd_en_c),
    .sclr_i (FLUSH),
    .ptr_o  (RD_ADDR)
  );

  assign WR_EN  = wr_en_c;
  assign RD_EN  = rd_en_c;
  assign LEVEL  = level_q;
  assign FULL   = full_q;
  assign EMPTY  = empty_q;
  assign AFULL  = afull_q;
  assign AEMPTY = aempty_q;
  assign OVF    = ovf_q;
  assign UDF    = udf_q;

endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for the FIFO_mix buffer. It sequences the write and read address counters and gates the write/read strobes to the storage array.
- Produces full, empty, almost-full, almost-empty, occupancy and sticky error flags, and supports a synchronous flush.
- Sits between the producer/consumer request interfaces and the dual-port RAM plus its address counters.

Parameters:
- ADDR_W, 8, address width; depth = 2**ADDR_W (256 by default).
- AF_LVL, 252, AFULL asserts when LEVEL >= AF_LVL.
- AE_LVL, 4, AEMPTY asserts when LEVEL <= AE_LVL.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- CLR  in  1  reset, asynchronous, active-high.
- WR_REQ  in  1  producer write request.
- RD_REQ  in  1  consumer read request.
- FLUSH  in  1  synchronous flush request, one-cycle pulse.
- ERR_CLR  in  1  clears the OVF and UDF flags.
- WR_EN  out  1  accepted write; RAM write enable and write-counter CE.
- RD_EN  out  1  accepted read; RAM read enable and read-counter CE.
- WR_ADDR  out  ADDR_W  current write pointer.
- RD_ADDR  out  ADDR_W  current read pointer.
- LEVEL  out  ADDR_W+1  occupancy, range 0..2**ADDR_W.
- FULL  out  1  FIFO full.
- EMPTY  out  1  FIFO empty.
- AFULL  out  1  almost full.
- AEMPTY  out  1  almost empty.
- OVF  out  1  sticky overflow.
- UDF  out  1  sticky underflow.

Behaviour:
- Reset (CLR=1, async): state=S_EMPTY; WR_ADDR=RD_ADDR=0; LEVEL=0; EMPTY=1; AEMPTY=1; FULL=AFULL=OVF=UDF=0.
- State machine states: S_EMPTY, S_PART, S_FULL, S_FLUSH.
  - EMPTY = (S_EMPTY or S_FLUSH).
  - FULL = S_FULL.
- Strobes are combinational from the registered flags:
  - WR_EN = WR_REQ & ~FULL & ~FLUSH & (state != S_FLUSH).
  - RD_EN = RD_REQ & ~EMPTY & ~FLUSH & (state != S_FLUSH).
- On each accepted write, WR_ADDR increments at the edge, wrapping modulo 2**ADDR_W. RD_ADDR behaves the same on each accepted read.
- LEVEL update at the edge:
  - +1 on write only.
  - -1 on read only.
  - unchanged on both or neither.
- Latency: LEVEL, FULL/EMPTY, AFULL/AEMPTY and the state all update at the same edge as the accepted operation. They are visible one cycle after the request.
- Transitions:
  - S_EMPTY -> S_PART on a write.
  - S_PART -> S_FULL when the next LEVEL = 2**ADDR_W.
  - S_PART -> S_EMPTY when the next LEVEL = 0.
  - S_FULL -> S_PART on a read.
  - Any state -> S_FLUSH when FLUSH=1.
  - S_FLUSH -> S_EMPTY unconditionally after one cycle.
- Simultaneous WR_REQ and RD_REQ:
  - In S_PART, both are accepted and LEVEL is unchanged.
  - In S_EMPTY, only the write is accepted (no fall-through); UDF is set.
  - In S_FULL, only the read is accepted; LEVEL becomes DEPTH-1 and OVF is set.
- FLUSH sampled high:
  - Pointers and LEVEL are cleared at that edge; AEMPTY=1, AFULL=0.
  - Requests in the FLUSH cycle and in the S_FLUSH cycle are dropped without setting OVF or UDF.
  - FLUSH has priority over every request.
- AFULL and AEMPTY are registered, computed from the next LEVEL.
- Error flags:
  - OVF is set on WR_REQ & FULL.
  - UDF is set on RD_REQ & EMPTY, outside S_FLUSH.
  - ERR_CLR clears both; a set in the same cycle wins over the clear.
- Pointer wrap is invisible to the flags; full/empty are decided by LEVEL, not by pointer comparison.
- CLR asserted mid-operation returns all outputs to their reset values immediately, with no dependence on the clock.

Decomposition:
- Shared package fifo_pkg:
  - state encoding constants for S_EMPTY, S_PART, S_FULL, S_FLUSH;
  - DEPTH = 2**ADDR_W;
  - default AF_LVL and AE_LVL values.
- One sub-module, fifo_ptr:
  - an ADDR_W-bit wrapping pointer with CE, synchronous clear (for flush) and async CLR;
  - instantiated twice, for write and read.

Test Plan:
- Reset then idle -> EMPTY=1, AEMPTY=1, LEVEL=0, WR_EN=RD_EN=0; RD_REQ=1 sets UDF=1 next cycle.
- 256 consecutive writes -> LEVEL=256, FULL=1, AFULL rises after the 252nd write, WR_ADDR=0 (wrapped); a 257th WR_REQ gives WR_EN=0 and OVF=1.
- From full, WR_REQ and RD_REQ together -> only RD_EN=1; LEVEL=255, FULL=0, OVF=1.
- With LEVEL=10, WR_REQ and RD_REQ for 300 cycles -> LEVEL stays 10, both pointers wrap past 255, no flags change.
- With LEVEL=100, FLUSH pulse with WR_REQ=1 -> WR_EN=0; next cycle LEVEL=0, pointers 0, EMPTY=1; requests ignored for one cycle, then accepted.
- CLR pulse between clock edges with LEVEL=50 and OVF=1 -> LEVEL=0, OVF=0, EMPTY=1 immediately; ERR_CLR with a simultaneous overflow leaves OVF=1.
